// File: rtl/figan_fx_pkg.sv
// Fixed-point constants and types shared by the FIGAN generator datapath stages.
// Q8.8 samples, activation encodings and the 16-bit saturation bounds.
package figan_fx_pkg;

    localparam int FRAC_BITS = 8;
    localparam int Q_WIDTH   = 16;

    localparam int ACT_RELU  = 0;
    localparam int ACT_LEAKY = 1;
    localparam int ACT_IDENT = 2;

    localparam logic signed [Q_WIDTH-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [Q_WIDTH-1:0] SAT_MIN = 16'sh8000;

    typedef logic signed [Q_WIDTH-1:0] q88_t;

endpackage

// File: rtl/fx_saturate.sv
// Clamps a wide signed value into a narrower signed range and flags when clamping occurred.
// Purely combinational so callers choose where to register.
module fx_saturate #(
    parameter int W_IN  = 33,
    parameter int W_OUT = 16
) (
    input  logic signed [W_IN-1:0]  i_val,
    output logic signed [W_OUT-1:0] o_val,
    output logic                    o_sat
);

    logic              w_sign;
    logic [W_IN-W_OUT:0] w_top;

    assign w_sign = i_val[W_IN-1];
    assign w_top  = i_val[W_IN-1:W_OUT-1];

    // The value fits exactly when every bit above the output sign bit copies the sign.
    assign o_sat  = (w_top != {(W_IN-W_OUT+1){w_sign}});

    assign o_val  = !o_sat ? i_val[W_OUT-1:0]
                  : w_sign ? {1'b1, {(W_OUT-1){1'b0}}}
                  :          {1'b0, {(W_OUT-1){1'b1}}};

endmodule

// File: rtl/bn_act_layer.sv
// Streaming batch-norm affine + activation stage: three-stage pipeline with a global stall,
// frame position tracking for last_out, and a per-frame saturation counter.
module bn_act_layer
    import figan_fx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = figan_fx_pkg::FRAC_BITS,
    parameter int OUT_W      = 32,
    parameter int OUT_H      = 32,
    parameter int ACT        = ACT_LEAKY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    input  logic [DATA_WIDTH-1:0] scale,
    input  logic [DATA_WIDTH-1:0] shift,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  last_out,
    output logic [15:0]           sat_cnt
);

    localparam int PW   = 2 * DATA_WIDTH;
    localparam int WIDE = PW + 1;
    localparam int CW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    logic                         w_en;
    logic signed [PW-1:0]         w_prod;
    logic signed [WIDE-1:0]       w_sum;
    logic signed [DATA_WIDTH-1:0] w_clamped;
    logic                         w_sat;
    logic signed [DATA_WIDTH-1:0] w_act;
    logic                         w_xfer;
    logic                         w_col_last;
    logic                         w_row_last;
    logic                         w_first;

    logic                         r_v1;
    logic signed [PW-1:0]         r_p1;
    logic                         r_v2;
    logic signed [DATA_WIDTH-1:0] r_a2;
    logic                         r_sat2;
    logic                         r_v3;
    logic signed [DATA_WIDTH-1:0] r_d3;
    logic                         r_sat3;
    logic [CW-1:0]                r_col;
    logic [RW-1:0]                r_row;
    logic [15:0]                  r_sat_cnt;

    assign w_en      = ready_in | ~r_v3;
    assign ready_out = w_en;

    assign w_prod = $signed(data_in) * $signed(scale);

    // Summed at full product width so nothing wraps before the clamp decides.
    assign w_sum = WIDE'(r_p1 >>> FRAC_BITS) + WIDE'($signed(shift));

    fx_saturate #(
        .W_IN  (WIDE),
        .W_OUT (DATA_WIDTH)
    ) u_sat (
        .i_val (w_sum),
        .o_val (w_clamped),
        .o_sat (w_sat)
    );

    always_comb begin
        w_act = r_a2;
        case (ACT)
            ACT_RELU:  if (r_a2[DATA_WIDTH-1]) w_act = '0;
            ACT_LEAKY: if (r_a2[DATA_WIDTH-1]) w_act = r_a2 >>> 3;
            default:   w_act = r_a2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_p1   <= '0;
            r_v2   <= 1'b0;
            r_a2   <= '0;
            r_sat2 <= 1'b0;
            r_v3   <= 1'b0;
            r_d3   <= '0;
            r_sat3 <= 1'b0;
        end else if (w_en) begin
            r_v1   <= valid_in;
            r_p1   <= w_prod;
            r_v2   <= r_v1;
            r_a2   <= w_clamped;
            r_sat2 <= w_sat;
            r_v3   <= r_v2;
            r_d3   <= w_act;
            r_sat3 <= r_sat2;
        end
    end

    assign w_xfer     = r_v3 & ready_in;
    assign w_col_last = (r_col == CW'(OUT_W - 1));
    assign w_row_last = (r_row == RW'(OUT_H - 1));
    assign w_first    = (r_col == '0) && (r_row == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_sat_cnt <= '0;
        end else if (w_xfer) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
            // First pixel of a frame restarts the count, keeping its own saturation.
            if (w_first) begin
                r_sat_cnt <= {15'd0, r_sat3};
            end else if (r_sat3 && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

    assign valid_out = r_v3;
    assign data_out  = r_d3;
    assign last_out  = r_v3 & w_col_last & w_row_last;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_bn_act_layer.sv
// Bench for bn_act_layer: three 4x4-frame instances (ReLU, Leaky, identity) share stimulus;
// a negedge monitor pops scoreboard entries on every output transfer.
module tb_bn_act_layer;
    import figan_fx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, ready_in;
    logic [15:0] data_in, scale, shift;

    logic        ro_id, vo_id, lo_id;
    logic [15:0] do_id, sc_id;
    logic        ro_re, vo_re, lo_re;
    logic [15:0] do_re, sc_re;
    logic        ro_lk, vo_lk, lo_lk;
    logic [15:0] do_lk, sc_lk;

    always #5 clk = ~clk;

    bn_act_layer #(.DATA_WIDTH(16), .FRAC_BITS(8), .OUT_W(4), .OUT_H(4), .ACT(ACT_IDENT)) u_id (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready_out(ro_id),
        .scale(scale), .shift(shift), .ready_in(ready_in), .valid_out(vo_id), .data_out(do_id),
        .last_out(lo_id), .sat_cnt(sc_id));
    bn_act_layer #(.DATA_WIDTH(16), .FRAC_BITS(8), .OUT_W(4), .OUT_H(4), .ACT(ACT_RELU)) u_re (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready_out(ro_re),
        .scale(scale), .shift(shift), .ready_in(ready_in), .valid_out(vo_re), .data_out(do_re),
        .last_out(lo_re), .sat_cnt(sc_re));
    bn_act_layer #(.DATA_WIDTH(16), .FRAC_BITS(8), .OUT_W(4), .OUT_H(4), .ACT(ACT_LEAKY)) u_lk (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready_out(ro_lk),
        .scale(scale), .shift(shift), .ready_in(ready_in), .valid_out(vo_lk), .data_out(do_lk),
        .last_out(lo_lk), .sat_cnt(sc_lk));

    typedef struct {
        logic [15:0] id;
        logic [15:0] relu;
        logic [15:0] leaky;
        logic        sat;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    bit          mon_en = 1'b0;
    int          out_count = 0;
    int          m_pix = 0;
    logic [15:0] m_sat = 16'd0;
    int          last_idx[$];

    function automatic exp_t model(input logic [15:0] d, input logic [15:0] sc, input logic [15:0] sh);
        exp_t   e;
        longint p, a, l;
        p = longint'($signed(d)) * longint'($signed(sc));
        a = (p >>> 8) + longint'($signed(sh));
        e.sat = 1'b0;
        if (a > longint'(SAT_MAX)) begin a = longint'(SAT_MAX); e.sat = 1'b1; end
        else if (a < longint'(SAT_MIN)) begin a = longint'(SAT_MIN); e.sat = 1'b1; end
        l = a >>> 3;
        e.id    = a[15:0];
        e.relu  = (a < 0) ? 16'h0000 : a[15:0];
        e.leaky = (a < 0) ? l[15:0] : a[15:0];
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n && vo_id && ready_in) begin
            out_count++;
            if (lo_id) last_idx.push_back(out_count);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow out#%0d data_out=%h but nothing expected", out_count, do_id);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (do_id !== mon_e.id)
                    begin failures++; $display("FAIL ident_data out#%0d got=%h exp=%h", out_count, do_id, mon_e.id); end
                checks++;
                if (vo_re !== 1'b1 || do_re !== mon_e.relu)
                    begin failures++; $display("FAIL relu_data out#%0d got=%h v=%b exp=%h", out_count, do_re, vo_re, mon_e.relu); end
                checks++;
                if (vo_lk !== 1'b1 || do_lk !== mon_e.leaky)
                    begin failures++; $display("FAIL leaky_data out#%0d got=%h v=%b exp=%h", out_count, do_lk, vo_lk, mon_e.leaky); end
                checks++;
                if (lo_id !== (m_pix == 15) || lo_re !== lo_id || lo_lk !== lo_id)
                    begin failures++; $display("FAIL last_out out#%0d got=%b exp=%b", out_count, lo_id, (m_pix == 15)); end
                checks++;
                if (sc_id !== m_sat || sc_re !== m_sat || sc_lk !== m_sat)
                    begin failures++; $display("FAIL sat_cnt out#%0d got=%0d exp=%0d", out_count, sc_id, m_sat); end
                if (m_pix == 0) m_sat = {15'd0, mon_e.sat};
                else if (mon_e.sat && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
                m_pix = (m_pix + 1) % 16;
            end
        end
    end

    task automatic send(input logic [15:0] d);
        bit acc = 1'b0;
        int n = 0;
        valid_in = 1'b1;
        data_in  = d;
        while (!acc) begin
            @(negedge clk);
            if (ro_id) begin acc = 1'b1; sb.push_back(model(d, scale, shift)); end
            @(posedge clk); #1;
            n++;
            if (!acc && n >= 50) begin
                checks++; failures++;
                $display("FAIL send_timeout ready_out=%b exp=1", ro_id);
                break;
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!vo_id && n < 20) begin @(negedge clk); n++; end
        if (!vo_id) begin
            checks++; failures++;
            $display("FAIL wait_out_timeout valid_out=%b exp=1", vo_id);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; valid_in = 1'b0;
        @(posedge clk); #1;
        sb.delete(); last_idx.delete();
        m_pix = 0; m_sat = 16'd0; out_count = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (vo_id !== 1'b0 || vo_re !== 1'b0 || vo_lk !== 1'b0)
            begin failures++; $display("FAIL reset_valid got=%b exp=0", vo_id); end
        checks++;
        if (do_id !== 16'h0 || lo_id !== 1'b0 || sc_id !== 16'h0)
            begin failures++; $display("FAIL reset_outs data=%h last=%b sat=%h exp=0", do_id, lo_id, sc_id); end
        checks++;
        if (ro_id !== 1'b1)
            begin failures++; $display("FAIL reset_ready got=%b exp=1", ro_id); end
        checks++;
        if (u_id.r_col !== 2'd0 || u_id.r_row !== 2'd0)
            begin failures++; $display("FAIL reset_counters row=%0d col=%0d exp=0", u_id.r_row, u_id.r_col); end
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        scale = 16'h0100; shift = 16'h0000;
        valid_in = 1'b1; data_in = 16'h0280;
        sb.push_back(model(16'h0280, scale, shift));
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            checks++;
            if (vo_id !== (c == 3))
                begin failures++; $display("FAIL latency cycle%0d valid_out=%b exp=%b", c, vo_id, (c == 3)); end
        end
        checks++;
        if (do_id !== 16'h0280 || sc_id !== 16'h0)
            begin failures++; $display("FAIL passthrough data=%h sat=%0d exp=0280/0", do_id, sc_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_activations();
        logic [15:0] sh_v[2] = '{16'h0000, 16'hFF00};
        logic [15:0] d_v[2]  = '{16'hFF00, 16'h0080};
        logic [15:0] e_id[2] = '{16'hFF00, 16'hFF80};
        logic [15:0] e_lk[2] = '{16'hFFE0, 16'hFFF0};
        scale = 16'h0100;
        for (int i = 0; i < 2; i++) begin
            shift = sh_v[i];
            send(d_v[i]);
            wait_out();
            checks++;
            if (do_id !== e_id[i] || do_re !== 16'h0000 || do_lk !== e_lk[i])
                begin failures++; $display("FAIL activation%0d id=%h relu=%h leaky=%h exp=%h/0000/%h", i, do_id, do_re, do_lk, e_id[i], e_lk[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        scale = 16'h0200; shift = 16'h0000;
        send(16'h7000);
        wait_out();
        checks++;
        if (do_id !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%h exp=7fff", do_id); end
        @(posedge clk); #1;
        checks++;
        if (sc_id !== 16'd1) begin failures++; $display("FAIL sat_cnt_1 got=%0d exp=1", sc_id); end
        send(16'h9000);
        wait_out();
        checks++;
        if (do_id !== 16'h8000) begin failures++; $display("FAIL sat_neg got=%h exp=8000", do_id); end
        @(posedge clk); #1;
        checks++;
        if (sc_id !== 16'd2) begin failures++; $display("FAIL sat_cnt_2 got=%0d exp=2", sc_id); end
        for (int i = 0; i < 14; i++) send(16'h0100);
        wait_drain();
        checks++;
        if (sc_id !== 16'd2) begin failures++; $display("FAIL sat_cnt_hold got=%0d exp=2", sc_id); end
        send(16'h7000);
        wait_drain();
        checks++;
        if (sc_id !== 16'd1) begin failures++; $display("FAIL sat_clear_inc got=%0d exp=1", sc_id); end
        for (int i = 0; i < 15; i++) send(16'h0010);
        wait_drain();
        send(16'h0010);
        wait_drain();
        checks++;
        if (sc_id !== 16'd0) begin failures++; $display("FAIL sat_clear got=%0d exp=0", sc_id); end
    endtask

    task automatic test_backpressure();
        int start_cnt;
        logic [15:0] held;
        logic        held_last;
        start_cnt = out_count;
        scale = 16'h0180; shift = 16'h0040;
        fork
            begin
                for (int i = 0; i < 10; i++) send(16'($urandom_range(0, 65535)));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                ready_in = 1'b0;
                @(negedge clk);
                held = do_id; held_last = lo_id;
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    checks++;
                    if (ro_id !== 1'b0 || vo_id !== 1'b1)
                        begin failures++; $display("FAIL stall_ready c%0d ready_out=%b valid_out=%b exp=0/1", c, ro_id, vo_id); end
                    checks++;
                    if (do_id !== held || lo_id !== held_last)
                        begin failures++; $display("FAIL stall_hold c%0d data=%h exp=%h", c, do_id, held); end
                end
                @(posedge clk); #1;
                ready_in = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (out_count - start_cnt !== 10)
            begin failures++; $display("FAIL bp_count got=%0d exp=10", out_count - start_cnt); end
    endtask

    task automatic test_framing();
        do_reset();
        scale = 16'h0100; shift = 16'h0000;
        for (int i = 0; i < 40; i++) send(16'(i * 37));
        wait_drain();
        checks++;
        if (out_count !== 40) begin failures++; $display("FAIL frame_count got=%0d exp=40", out_count); end
        checks++;
        if (last_idx.size() != 2 || last_idx[0] != 16 || last_idx[1] != 32)
            begin failures++; $display("FAIL frame_last pulses=%0d first=%0d exp=2 at 16,32", last_idx.size(), (last_idx.size() > 0) ? last_idx[0] : -1); end
        checks++;
        if (u_id.r_row !== 2'd2 || u_id.r_col !== 2'd0)
            begin failures++; $display("FAIL frame_pos row=%0d col=%0d exp=2/0", u_id.r_row, u_id.r_col); end
    endtask

    task automatic test_reset_midframe();
        scale = 16'h0100; shift = 16'h0010;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            send(16'(i * 5));
            if (out_count >= 7) break;
        end
        rst_n = 1'b0; valid_in = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (vo_id !== 1'b0 || vo_re !== 1'b0 || vo_lk !== 1'b0)
            begin failures++; $display("FAIL midreset_valid got=%b exp=0", vo_id); end
        sb.delete(); last_idx.delete();
        m_pix = 0; m_sat = 16'd0; out_count = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send(16'(16'h0100 + i));
        wait_drain();
        checks++;
        if (out_count !== 16 || last_idx.size() != 1 || last_idx[0] != 16)
            begin failures++; $display("FAIL midreset_frame outs=%0d pulses=%0d exp=16/1", out_count, last_idx.size()); end
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        data_in = 16'h0; scale = 16'h0100; shift = 16'h0;
        test_reset();
        mon_en = 1'b1;
        test_passthrough();
        test_activations();
        test_saturation();
        test_backpressure();
        test_framing();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time=%0t exp=finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
